display_ctrl: RTL

DISPLAY_CTRL -- requirements
Module: display_ctrl

---
 rtl/display_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/display_ctrl.sv
// display_ctrl: four-digit multiplexed display scanner.
// A free-running prescaler produces one slot of REFRESH_DIV clocks per digit.
// seg_sel selects the digit (00 S_lo, 01 S_hi, 10 R_lo, 11 R_hi), and anode/dp
// light that digit. All outputs are registered and update on the same edge.
// Optional macro DISP_GHOST_BLANK_EN: after each digit advance, the anodes are
// held dark for BLANK_CYCLES clocks to suppress ghosting.
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   digit_en  per-digit enable (bit i = digit i may light)
//   dp_in     per-digit decimal point request
//   seg_sel   current digit index for the downstream nibble mux
//   anode     active-low digit enables (one-hot-low or all high)
//   dp        active-low decimal point for the lit digit
//   tick      one-cycle pulse in the last prescaler cycle of each slot
module display_ctrl #(
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] digit_en,
   input  logic [3:0] dp_in,
   output logic [1:0] seg_sel,
   output logic [3:0] anode,
   output logic       dp,
   output logic       tick
);

   localparam int unsigned PW = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] PRE_TICK = PW'(REFRESH_DIV - 2);

   // Elaboration-time parameter range check
   if (REFRESH_DIV < 4 || REFRESH_DIV > (1 << 20)) begin : g_bad_div
      $error("display_ctrl: REFRESH_DIV out of range");
   end

   logic [PW-1:0] presc;
   logic [1:0]    sel_next_c;

   function automatic logic [3:0] lit_anode(input logic [1:0] sel, input logic [3:0] en);
      return ~((4'b0001 << sel) & en);
   endfunction

   function automatic logic lit_dp(input logic [1:0] sel, input logic [3:0] en,
                                   input logic [3:0] dpi);
      return ~(dpi[sel] & en[sel]);
   endfunction

   // Prescaler; tick is registered one count early so it is high exactly while
   // the prescaler holds REFRESH_DIV-1, which makes it double as the wrap flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + PW'(1);
         tick  <= (presc == PRE_TICK);
      end
   end

   // Digit index after the current edge
   always_comb begin
      sel_next_c = seg_sel;
      if (tick) sel_next_c = seg_sel + 2'd1;
   end

`ifdef DISP_GHOST_BLANK_EN
   if (BLANK_CYCLES < 1 || BLANK_CYCLES > REFRESH_DIV - 2) begin : g_bad_blank
      $error("display_ctrl: BLANK_CYCLES out of range");
   end

   localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);

   typedef enum logic {SHOW, BLANK} state_t;

   state_t        state;
   logic [BW-1:0] bcnt;

   // Scan FSM. BLANK always ends before the next tick, so seg_sel is stable
   // for the whole dark interval and the lit value uses the new digit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= SHOW;
         bcnt    <= '0;
         seg_sel <= 2'b00;
         anode   <= 4'b1111;
         dp      <= 1'b1;
      end else begin
         seg_sel <= sel_next_c;
         case (state)
            SHOW: begin
               if (tick) begin
                  state <= BLANK;
                  bcnt  <= BW'(BLANK_CYCLES - 1);
                  anode <= 4'b1111;
                  dp    <= 1'b1;
               end else begin
                  anode <= lit_anode(seg_sel, digit_en);
                  dp    <= lit_dp(seg_sel, digit_en, dp_in);
               end
            end
            BLANK: begin
               if (bcnt == '0) begin
                  state <= SHOW;
                  anode <= lit_anode(seg_sel, digit_en);
                  dp    <= lit_dp(seg_sel, digit_en, dp_in);
               end else begin
                  bcnt  <= bcnt - BW'(1);
                  anode <= 4'b1111;
                  dp    <= 1'b1;
               end
            end
            default: begin
               state <= SHOW;
               anode <= 4'b1111;
               dp    <= 1'b1;
            end
         endcase
      end
   end
`else
   // Direct scan: the lit value always follows the next digit index
   always_ff @(posedge clk) begin
      if (reset) begin
         seg_sel <= 2'b00;
         anode   <= 4'b1111;
         dp      <= 1'b1;
      end else begin
         seg_sel <= sel_next_c;
         anode   <= lit_anode(sel_next_c, digit_en);
         dp      <= lit_dp(sel_next_c, digit_en, dp_in);
      end
   end
`endif

endmodule
